axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of AXI read requester ports (2..8).
REQ-002 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port s_araddr  input  NUM_PORTS*32  per-port read address; port i at bits [32i+31:32i].
REQ-005 SHALL have port s_arlen  input  NUM_PORTS*8  per-port burst length; beats = arlen+1; port i at [8i+7:8i].
REQ-006 SHALL have port s_arvalid  input  NUM_PORTS  per-port address valid.
REQ-007 SHALL have port s_arready  output  NUM_PORTS  per-port address accept.
REQ-008 SHALL have port s_rvalid  output  NUM_PORTS  per-port read data valid.
REQ-009 SHALL have port s_rready  input  NUM_PORTS  per-port read data ready.
REQ-010 SHALL have port s_rdata  output  32  read data, broadcast to all ports.
REQ-011 SHALL have ports m_araddr (output, 32), m_arlen (output, 8), m_arvalid (output, 1) and m_arready (input, 1): downstream AXI address channel.
REQ-012 SHALL have ports m_rvalid (input, 1), m_rready (output, 1) and m_rdata (input, 32): downstream AXI read data channel.
REQ-013 SHALL have port grant_id  output  3  index of the port owning the current transaction; hold value when IDLE.

Function
REQ-014 SHALL implement three states: IDLE, ADDR, BURST.
REQ-015 IDLE: if any s_arvalid is set, SHALL grant the first requesting port in round-robin order starting at last_grant+1 (mod NUM_PORTS), latch its araddr/arlen and grant_id, and go to ADDR next cycle.
REQ-016 ADDR: m_arvalid=1, m_araddr/m_arlen from latched values; on m_arready, s_arready[grant_id]=1 in the same cycle (combinational), beats_left<=arlen+1, go to BURST.
REQ-017 s_arready SHALL be 0 for all ports outside ADDR, and for non-granted ports always.
REQ-018 BURST: m_rready=s_rready[grant_id], s_rvalid[grant_id]=m_rvalid; all other s_rvalid=0; m_rready=0 outside BURST.
REQ-019 BURST: each m_rvalid&&m_rready SHALL decrement beats_left (9-bit); the beat at beats_left==1 SHALL return to IDLE and set last_grant<=grant_id.
REQ-020 s_rdata SHALL equal m_rdata combinationally in all states.
REQ-021 Latency: s_arvalid first seen high in cycle N with arbiter IDLE -> m_arvalid high in cycle N+1; one IDLE cycle minimum between bursts.
REQ-022 arlen=0 SHALL produce a one-beat burst; arlen=255 SHALL produce 256 beats without counter wrap.
REQ-023 Simultaneous requests: after port k completes, port k+1..NUM_PORTS-1 then 0..k SHALL be served in that order; no port waits more than NUM_PORTS-1 bursts.
REQ-024 Requests arriving during ADDR/BURST SHALL be held off (arready=0) and arbitrated in the next IDLE.
REQ-025 Latched address/length SHALL not change between grant and the end of BURST regardless of s_araddr activity.

Reset
REQ-026 On reset: state=IDLE, last_grant=NUM_PORTS-1 (port 0 first), grant_id=0, beats_left=0, latched addr/len=0.
REQ-027 Reset outputs: m_arvalid=0, m_rready=0, s_arready=0, s_rvalid=0.
REQ-028 Reset asserted mid-ADDR or mid-BURST SHALL abandon the transaction immediately with no further handshakes.

Structure
REQ-029 Shared package SHALL hold state enum (IDLE/ADDR/BURST) and AXI width constants (address 32, len 8, data 32).
REQ-030 SHALL instantiate one sub-module rr_arbiter: combinational request vector + last_grant -> one-hot grant and index.
REQ-031 Target 150-300 lines of RTL total.

Verification
REQ-032 Single request: port 1 araddr=0x00001000, arlen=3; m_arready immediate -> m_arvalid cycle N+1, 4 beats to port 1, IDLE after 4th beat.
REQ-033 All ports request after reset, arlen=0 each -> grants in order 0,1,2, then repeat 0 if still requesting.
REQ-034 Backpressure: arlen=7, s_rready toggles every cycle -> exactly 8 beats delivered, m_rready mirrors s_rready.
REQ-035 Max burst: arlen=255 -> 256 beats, beats_left never wraps, returns to IDLE.
REQ-036 Reset at beat 3 of an 8-beat burst -> all outputs 0 next edge, next request granted to port 0.
REQ-037 m_arready held low 10 cycles -> m_arvalid stays high and m_araddr stable; s_arready pulses only on acceptance.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and AXI width constants for the round-robin AXI read arbiter.
package axi_read_arbiter_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned BEATS_W    = AXI_LEN_W + 1;
    localparam int unsigned GRANT_W    = 3;
    localparam int unsigned IDX_W      = GRANT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        BURST = 2'd2
    } state_e;

    // (base + off) mod n, valid for base < n and off <= n
    function automatic logic [GRANT_W-1:0] rr_next(
        input logic [GRANT_W-1:0] base,
        input int unsigned        off,
        input int unsigned        n
    );
        logic [IDX_W-1:0] sum;
        sum = IDX_W'(base) + IDX_W'(off);
        if (sum >= IDX_W'(n)) begin
            sum = sum - IDX_W'(n);
        end
        return GRANT_W'(sum);
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after i_last_grant wins.
module rr_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [GRANT_W-1:0]   i_last_grant,
    output logic [NUM_PORTS-1:0] o_grant_oh_c,
    output logic [GRANT_W-1:0]   o_grant_idx_c,
    output logic                 o_valid_c
);

    always_comb begin : pick
        logic [GRANT_W-1:0] idx;
        o_grant_oh_c  = '0;
        o_grant_idx_c = '0;
        o_valid_c     = 1'b0;
        idx           = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = rr_next(i_last_grant, k, NUM_PORTS);
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!o_valid_c && i_req[i] && (idx == GRANT_W'(i))) begin
                    o_valid_c       = 1'b1;
                    o_grant_oh_c[i] = 1'b1;
                    o_grant_idx_c   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS AXI read requesters onto one
// downstream read port, one whole burst at a time.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*AXI_ADDR_W-1:0] s_araddr,
    input  logic [NUM_PORTS*AXI_LEN_W-1:0]  s_arlen,
    input  logic [NUM_PORTS-1:0]            s_arvalid,
    output logic [NUM_PORTS-1:0]            s_arready,
    output logic [NUM_PORTS-1:0]            s_rvalid,
    input  logic [NUM_PORTS-1:0]            s_rready,
    output logic [AXI_DATA_W-1:0]           s_rdata,
    output logic [AXI_ADDR_W-1:0]           m_araddr,
    output logic [AXI_LEN_W-1:0]            m_arlen,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    input  logic                            m_rvalid,
    output logic                            m_rready,
    input  logic [AXI_DATA_W-1:0]           m_rdata,
    output logic [GRANT_W-1:0]              grant_id
);

    state_e                r_state;
    state_e                w_next_state;
    logic [GRANT_W-1:0]    r_last_grant;
    logic [GRANT_W-1:0]    r_grant_id;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [AXI_LEN_W-1:0]  r_len;
    logic [BEATS_W-1:0]    r_beats_left;

    logic [NUM_PORTS-1:0]  w_grant_oh;
    logic [GRANT_W-1:0]    w_grant_idx;
    logic                  w_grant_valid;
    logic [AXI_ADDR_W-1:0] w_sel_addr;
    logic [AXI_LEN_W-1:0]  w_sel_len;
    logic [NUM_PORTS-1:0]  w_port_sel;
    logic                  w_gnt_rready;
    logic                  w_latch;
    logic                  w_ar_hs;
    logic                  w_beat;
    logic                  w_last_beat;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .i_req         (s_arvalid),
        .i_last_grant  (r_last_grant),
        .o_grant_oh_c  (w_grant_oh),
        .o_grant_idx_c (w_grant_idx),
        .o_valid_c     (w_grant_valid)
    );

    // Winner's request fields and one-hot of the port owning the transaction
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_port_sel = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_addr = w_sel_addr | s_araddr[i*AXI_ADDR_W +: AXI_ADDR_W];
                w_sel_len  = w_sel_len  | s_arlen[i*AXI_LEN_W +: AXI_LEN_W];
            end
            w_port_sel[i] = (r_grant_id == GRANT_W'(i));
        end
    end

    assign w_gnt_rready = |(s_rready & w_port_sel);
    assign s_rdata      = m_rdata;
    assign m_araddr     = r_addr;
    assign m_arlen      = r_len;
    assign grant_id     = r_grant_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        m_arvalid    = 1'b0;
        m_rready     = 1'b0;
        s_arready    = '0;
        s_rvalid     = '0;
        w_latch      = 1'b0;
        w_ar_hs      = 1'b0;
        w_beat       = 1'b0;
        w_last_beat  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_latch      = 1'b1;
                    w_next_state = ADDR;
                end
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    w_ar_hs      = 1'b1;
                    s_arready    = w_port_sel;
                    w_next_state = BURST;
                end
            end
            BURST: begin
                m_rready = w_gnt_rready;
                s_rvalid = m_rvalid ? w_port_sel : '0;
                w_beat   = m_rvalid && w_gnt_rready;
                if (w_beat && (r_beats_left == BEATS_W'(1))) begin
                    w_last_beat  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Transaction context: held from grant until the final beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= GRANT_W'(NUM_PORTS - 1);
            r_grant_id   <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_beats_left <= '0;
        end else begin
            if (w_latch) begin
                r_grant_id <= w_grant_idx;
                r_addr     <= w_sel_addr;
                r_len      <= w_sel_len;
            end
            if (w_ar_hs) begin
                r_beats_left <= BEATS_W'(r_len) + BEATS_W'(1);
            end else if (w_beat) begin
                r_beats_left <= r_beats_left - BEATS_W'(1);
            end
            if (w_last_beat) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: expected grants and beats are queued
// as requests are driven and retired as handshakes appear.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int unsigned NP = 3;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NP*AXI_ADDR_W-1:0] s_araddr;
    logic [NP*AXI_LEN_W-1:0]  s_arlen;
    logic [NP-1:0]            s_arvalid;
    logic [NP-1:0]            s_arready;
    logic [NP-1:0]            s_rvalid;
    logic [NP-1:0]            s_rready;
    logic [AXI_DATA_W-1:0]    s_rdata;
    logic [AXI_ADDR_W-1:0]    m_araddr;
    logic [AXI_LEN_W-1:0]     m_arlen;
    logic                     m_arvalid;
    logic                     m_arready;
    logic                     m_rvalid;
    logic                     m_rready;
    logic [AXI_DATA_W-1:0]    m_rdata;
    logic [GRANT_W-1:0]       grant_id;

    always #5 clk = ~clk;

    axi_read_arbiter #(.NUM_PORTS(NP)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_rdata   (s_rdata),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .grant_id  (grant_id)
    );

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t         exp_ar[$];
    logic [31:0] exp_beat[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          slv_left = 0;
    int          slv_idx = 0;
    logic [31:0] slv_addr = '0;
    int          cur_grant = 0;
    int          beats_seen = 0;
    bit          drop_mode = 1'b1;
    bit          rr_toggle = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        return NP'(1 << p);
    endfunction

    task automatic request(input int p, input logic [31:0] addr, input logic [7:0] len);
        ar_t e;
        s_araddr[p*32 +: 32] = addr;
        s_arlen[p*8 +: 8]    = len;
        s_arvalid[p]         = 1'b1;
        e.port = p; e.addr = addr; e.len = len;
        exp_ar.push_back(e);
    endtask

    // One clock: slave drive, check the cycle's handshakes, then advance
    task automatic tick();
        logic          ar_hs, r_hs;
        logic [NP-1:0] exp_ard;
        logic [31:0]   hs_addr;
        logic [7:0]    hs_len;
        ar_t           e;
        if (rr_toggle) s_rready = ~s_rready;
        m_rvalid = (slv_left != 0) && ($urandom_range(0, 3) != 0);
        m_rdata  = slv_addr + 32'(slv_idx);
        #1;
        ar_hs   = m_arvalid && m_arready;
        exp_ard = '0;
        hs_addr = m_araddr;
        hs_len  = m_arlen;
        if (ar_hs) begin
            if (exp_ar.size() == 0) begin
                chk("ar_unexpected", 64'(1), 64'(0));
            end else begin
                e = exp_ar.pop_front();
                chk("ar_grant", 64'(grant_id), 64'(e.port));
                chk("ar_addr", 64'(m_araddr), 64'(e.addr));
                chk("ar_len", 64'(m_arlen), 64'(e.len));
                exp_ard   = oh(e.port);
                cur_grant = e.port;
                for (int b = 0; b <= int'(e.len); b++) exp_beat.push_back(e.addr + 32'(b));
            end
        end
        chk("s_arready", 64'(s_arready), 64'(exp_ard));
        chk("m_rready", 64'(m_rready), 64'((slv_left != 0) ? s_rready[cur_grant] : 1'b0));
        chk("s_rvalid", 64'(s_rvalid), 64'((slv_left != 0 && m_rvalid) ? oh(cur_grant) : '0));
        r_hs = (slv_left != 0) && m_rvalid && m_rready;
        if (r_hs) begin
            if (exp_beat.size() == 0) chk("beat_unexpected", 64'(1), 64'(0));
            else                      chk("s_rdata", 64'(s_rdata), 64'(exp_beat.pop_front()));
        end
        @(posedge clk);
        #1;
        if (ar_hs) begin
            slv_left = int'(hs_len) + 1;
            slv_addr = hs_addr;
            slv_idx  = 0;
        end
        if (r_hs) begin
            slv_left--;
            slv_idx++;
            beats_seen++;
        end
        if (drop_mode) s_arvalid = s_arvalid & ~exp_ard;
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            busy = (exp_ar.size() != 0) || (exp_beat.size() != 0) || (slv_left != 0);
            if (busy) begin
                tick();
                n++;
            end
        end
        busy = (exp_ar.size() != 0) || (exp_beat.size() != 0) || (slv_left != 0);
        chk("done_in_budget", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, n;
        logic [31:0] a_hold;
        reset     = 1'b1;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arvalid = '0;
        s_rready  = '1;
        m_arready = 1'b1;
        m_rvalid  = 1'b0;
        m_rdata   = 32'h5A5A_1234;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("rst_m_rready", 64'(m_rready), 64'(0));
        chk("rst_s_arready", 64'(s_arready), 64'(0));
        chk("rst_s_rvalid", 64'(s_rvalid), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rdata_passthru", 64'(s_rdata), 64'(32'h5A5A_1234));
        reset = 1'b0;
        tick();

        // Single request with first-cycle latency check
        b0 = beats_seen;
        request(1, 32'h0000_1000, 8'd3);
        #1;
        chk("lat_cycle_n", 64'(m_arvalid), 64'(0));
        tick();
        chk("lat_cycle_n1", 64'(m_arvalid), 64'(1));
        chk("lat_grant", 64'(grant_id), 64'(1));
        wait_done(200);
        chk("single_beats", 64'(beats_seen - b0), 64'(4));
        chk("single_idle", 64'(m_arvalid), 64'(0));

        // All ports keep requesting after reset: 0,1,2 then 0 again
        do_reset();
        drop_mode = 1'b0;
        b0 = beats_seen;
        for (int p = 0; p < int'(NP); p++) request(p, 32'h100 * (p + 1), 8'd0);
        begin
            ar_t e;
            e.port = 0; e.addr = 32'h100; e.len = 8'd0;
            exp_ar.push_back(e);
        end
        n = 0;
        while (exp_ar.size() != 0 && n < 200) begin tick(); n++; end
        chk("rr_in_budget", 64'(exp_ar.size()), 64'(0));
        s_arvalid = '0;
        drop_mode = 1'b1;
        wait_done(200);
        chk("rr_beats", 64'(beats_seen - b0), 64'(4));

        // Backpressure on port 2, with port 0 arriving mid-burst and held off
        b0 = beats_seen;
        rr_toggle = 1'b1;
        request(2, 32'h0000_3000, 8'd7);
        repeat (3) tick();
        request(0, 32'h0000_4000, 8'd0);
        wait_done(2000);
        rr_toggle = 1'b0;
        s_rready  = '1;
        chk("bp_beats", 64'(beats_seen - b0), 64'(9));

        // Maximum burst length
        b0 = beats_seen;
        request(1, 32'h0001_0000, 8'd255);
        wait_done(3000);
        chk("max_beats", 64'(beats_seen - b0), 64'(256));
        tick();
        chk("max_idle", 64'(m_arvalid), 64'(0));

        // Address channel stall: held address despite requester changes
        m_arready = 1'b0;
        a_hold = 32'hA000_0040;
        request(0, a_hold, 8'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            s_araddr[31:0] = $urandom;
            s_arlen[7:0]   = 8'($urandom);
            tick();
            chk("stall_arvalid", 64'(m_arvalid), 64'(1));
            chk("stall_araddr", 64'(m_araddr), 64'(a_hold));
            chk("stall_arlen", 64'(m_arlen), 64'(1));
        end
        m_arready = 1'b1;
        wait_done(200);

        // Reset in the middle of a burst
        b0 = beats_seen;
        request(2, 32'h0000_2000, 8'd7);
        n = 0;
        while ((beats_seen - b0) < 2 && n < 200) begin tick(); n++; end
        chk("pre_reset_beats", 64'(beats_seen - b0), 64'(2));
        m_rvalid = 1'b1;
        reset    = 1'b1;
        #1;
        chk("midrst_m_arvalid", 64'(m_arvalid), 64'(0));
        chk("midrst_m_rready", 64'(m_rready), 64'(0));
        chk("midrst_s_rvalid", 64'(s_rvalid), 64'(0));
        chk("midrst_s_arready", 64'(s_arready), 64'(0));
        chk("midrst_grant_id", 64'(grant_id), 64'(0));
        exp_ar.delete();
        exp_beat.delete();
        slv_left  = 0;
        s_arvalid = '0;
        tick();
        tick();
        reset = 1'b0;
        request(1, 32'h0000_5100, 8'd0);
        request(2, 32'h0000_5200, 8'd0);
        request(0, 32'h0000_5000, 8'd0);
        begin
            ar_t e0;
            e0 = exp_ar.pop_back();
            exp_ar.push_front(e0);
        end
        wait_done(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
